cache_resp_check: RTL and testbench
===================================

Name: cache_resp_check

Overview:
- Downstream stage of the cache test stimulus generator; sits on the cache's CPU-side response path.
- Records every request the cache accepts (address) in an in-order expectation FIFO.
- Checks every cache read response against a data pattern derived from that address.
- Counts responses and mismatches, detects lost responses by timeout, and applies back-pressure to the generator when too many requests are outstanding.

Parameters:
- AW, 16, request address width (2..16).
- DEPTH, 8, expectation FIFO depth; power of two, 2..16.
- TIMEOUT, 255, cycles without a response while requests are outstanding before timeout is flagged (1..65535).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_fire  in  1  request accepted by cache this cycle (generator valid & cache ready).
- req_addr  in  AW  address of the accepted request.
- resp_valid  in  1  cache delivers read data this cycle.
- resp_data  in  32  read data from cache.
- ready_out  out  1  high when FIFO not full; feeds generator ready_in (ANDed externally with cache ready).
- resp_count  out  16  responses received, saturating.
- err_count  out  16  errors (mismatch, unexpected response, overflow), saturating.
- timeout  out  1  sticky lost-response flag.
- fail  out  1  sticky: any error or timeout since reset.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high; ports named clk and rst.
- Reset values: FIFO empty, ready_out=1, resp_count=0, err_count=0, timeout=0, fail=0, timeout counter=0, FSM=IDLE.
- Reset mid-operation: outstanding entries are discarded, and all outputs return to their reset values immediately (asynchronous).
- Expected data: exp(a) = {~a16, a16}, where a16 = req_addr zero-extended to 16 bits.
  - Example: addr 16'h0004 gives 32'hFFFB0004.
- Push: on req_fire with FIFO not full, write req_addr at tail. Occupancy is visible at the next edge.
- Pop/compare: on resp_valid with FIFO non-empty at start of cycle, compare resp_data with exp(head) combinationally and pop head.
  - On mismatch: err_count+1 and fail set, both visible the cycle after resp_valid.
- resp_count increments on every resp_valid, including unexpected ones.
- Unexpected response: resp_valid with FIFO empty at start of cycle gives err_count+1 and fail=1. A same-cycle req_fire is still pushed.
- Overflow: req_fire while full (FIFO full at start of cycle) gives err_count+1 and fail=1, and the address is dropped.
  - This holds even if resp_valid pops in the same cycle.
- Simultaneous push and pop when neither overflow nor underflow applies: occupancy is unchanged and the pointers advance.
- ready_out = ~full, purely combinational from occupancy; no dependence on same-cycle resp_valid.
- Pointers wrap modulo DEPTH. Occupancy register is $clog2(DEPTH)+1 bits.
- Counters are 16 bits and saturate at 16'hFFFF (no wrap).
- Timeout counter is 16 bits:
  - cleared when FIFO empty or on resp_valid;
  - otherwise increments;
  - reaching TIMEOUT sets timeout=1 and fail=1, both sticky, and err_count+1 once.
  - After that the counter holds at TIMEOUT until a response or empty clears it.
- FSM, 2 bits:
  - IDLE: FIFO empty, no error. Goes to BUSY on push.
  - BUSY: outstanding > 0. Goes to IDLE when last entry pops without error; goes to FAILED on any error.
  - FAILED: terminal until reset. Checking continues and counters keep counting; only fail stays asserted.
  - Also IDLE to FAILED on unexpected response.

Optional Feature:
- Macro: CACHE_RESP_CHECK_CAPTURE_EN.
- Defined: adds outputs first_err_addr [AW-1:0] and first_err_data [31:0], reset to 0.
  - They latch the head address and resp_data of the first mismatch only; later errors do not overwrite them.
  - Unexpected, overflow and timeout errors capture address 0 and data 0 if they are first.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package cache_test_pkg:
  - exp_data function/macro;
  - FSM state encodings IDLE=2'd0, BUSY=2'd1, FAILED=2'd2;
  - counter width 16 and saturation constant 16'hFFFF.
- One natural sub-module: cache_resp_fifo, a synchronous FIFO (width AW, depth DEPTH) with full, empty and head outputs, and the same asynchronous reset.

Test Plan:
- Reset, then 4 requests addr 0,4,8,C, each answered 3 cycles later with the correct data (e.g. 32'hFFFB0004) -> resp_count=4, err_count=0, fail=0, FSM back to IDLE.
- Request addr 4, response 32'h00000000 -> err_count=1 and fail=1 on the cycle after resp_valid; capture enabled gives first_err_addr=4 and first_err_data=0.
- DEPTH=8: 8 requests with no responses -> ready_out=0 after the 8th push. A 9th req_fire -> err_count=1, fail=1, and the address is dropped.
- resp_valid with FIFO empty, same cycle as a req_fire of addr 8 -> err_count=1 and occupancy=1. The next response with 32'hFFF70008 is accepted with no additional error.
- TIMEOUT=20: one request with no response -> timeout=1 exactly 20 cycles after the push and err_count=1. A later correct response leaves timeout=1 and gives resp_count=1.
- Assert rst asynchronously mid-burst with 3 outstanding -> all outputs reset immediately, ready_out=1. A post-reset request/response pair checks clean.

Source files
------------

// File: rtl/cache_test_pkg.sv
// Shared definitions for the cache response checker: expected-data pattern,
// checker FSM encoding and counter width / saturation value.
package cache_test_pkg;

   localparam int unsigned CntW = 16;
   localparam logic [CntW-1:0] CntMax = 16'hFFFF;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StBusy   = 2'd1,
      StFailed = 2'd2
   } chk_state_e;

   // Expected read data for a request address: {~a16, a16}
   function automatic logic [31:0] exp_data(input logic [15:0] a16);
      return {~a16, a16};
   endfunction

endpackage

// File: rtl/cache_resp_fifo.sv
// In-order expectation FIFO holding accepted request addresses.
// Caller guarantees push only when not full and pop only when not empty.
module cache_resp_fifo #(
   parameter int unsigned Width = 16,
   parameter int unsigned Depth = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [Width-1:0]           wdata,
   output logic                       full,
   output logic                       empty,
   output logic [Width-1:0]           head,
   output logic [$clog2(Depth):0]     count
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q;

   // Storage array; contents are don't-care while empty, so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers and occupancy; Depth is a power of two so pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Status flags and head of queue
   always_comb begin
      full  = (cnt_q == CntW'(Depth));
      empty = (cnt_q == '0);
      head  = mem_q[rd_ptr_q];
      count = cnt_q;
   end

endmodule

// File: rtl/cache_resp_check.sv
// Cache response checker: records accepted request addresses, checks read
// responses in order against exp_data(addr), counts responses and errors,
// flags lost responses by timeout and back-pressures the generator.
// Optional capture of the first error: define CACHE_RESP_CHECK_CAPTURE_EN.
module cache_resp_check
   import cache_test_pkg::*;
#(
   parameter int unsigned AW      = 16,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_fire,
   input  logic [AW-1:0]   req_addr,
   input  logic            resp_valid,
   input  logic [31:0]     resp_data,
   output logic            ready_out,
   output logic [15:0]     resp_count,
   output logic [15:0]     err_count,
   output logic            timeout,
`ifdef CACHE_RESP_CHECK_CAPTURE_EN
   output logic [AW-1:0]   first_err_addr,
   output logic [31:0]     first_err_data,
`endif
   output logic            fail
);

   localparam logic [CntW-1:0] TmoMax = CntW'(TIMEOUT);

   logic                  full, empty, push, pop;
   logic [AW-1:0]         head;
   logic [15:0]           head16;
   logic [$clog2(DEPTH):0] occ;
   logic                  mismatch, unexpected, overflow, tmo_clr, tmo_hit, any_err;
   logic [1:0]            err_inc;
   logic [CntW:0]         err_sum;
   logic [CntW-1:0]       resp_q, resp_d, err_q, err_d, tmo_cnt_q, tmo_cnt_d;
   logic                  timeout_q;
   chk_state_e            state_q, state_d;

   cache_resp_fifo #(
      .Width (AW),
      .Depth (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (req_addr),
      .full  (full),
      .empty (empty),
      .head  (head),
      .count (occ)
   );

   // Error detection, timeout counting, saturating counters and FSM next state
   always_comb begin
      head16         = '0;
      head16[AW-1:0] = head;

      push       = req_fire & ~full;
      pop        = resp_valid & ~empty;
      mismatch   = pop & (resp_data != exp_data(head16));
      unexpected = resp_valid & empty;
      overflow   = req_fire & full;

      // Counter holds at TmoMax after firing so the error is counted once
      tmo_clr = empty | resp_valid;
      tmo_hit = ~tmo_clr & (tmo_cnt_q == TmoMax - CntW'(1));
      if (tmo_clr) begin
         tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TmoMax) begin
         tmo_cnt_d = tmo_cnt_q;
      end else begin
         tmo_cnt_d = tmo_cnt_q + CntW'(1);
      end

      any_err = mismatch | unexpected | overflow | tmo_hit;

      // Several error kinds can coincide; each one is counted
      err_inc = {1'b0, mismatch | unexpected} + {1'b0, overflow} + {1'b0, tmo_hit};
      err_sum = {1'b0, err_q} + (CntW + 1)'(err_inc);
      err_d   = err_sum[CntW] ? CntMax : err_sum[CntW-1:0];

      resp_d = (resp_valid && resp_q != CntMax) ? resp_q + CntW'(1) : resp_q;

      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (any_err)   state_d = StFailed;
            else if (push) state_d = StBusy;
         end
         StBusy: begin
            if (any_err)                                        state_d = StFailed;
            else if (pop && !push && occ == ($clog2(DEPTH)+1)'(1)) state_d = StIdle;
         end
         StFailed: state_d = StFailed;
         default:  state_d = StIdle;
      endcase
   end

   // Checker state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_q    <= '0;
         err_q     <= '0;
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
         state_q   <= StIdle;
      end else begin
         resp_q    <= resp_d;
         err_q     <= err_d;
         tmo_cnt_q <= tmo_cnt_d;
         state_q   <= state_d;
         if (tmo_hit) timeout_q <= 1'b1;
      end
   end

`ifdef CACHE_RESP_CHECK_CAPTURE_EN
   logic [AW-1:0] cap_addr_q;
   logic [31:0]   cap_data_q;

   // Latch the first error only; non-mismatch errors record zeros
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_addr_q <= '0;
         cap_data_q <= '0;
      end else if (any_err && state_q != StFailed) begin
         cap_addr_q <= mismatch ? head : '0;
         cap_data_q <= mismatch ? resp_data : '0;
      end
   end

   assign first_err_addr = cap_addr_q;
   assign first_err_data = cap_data_q;
`endif

   // Outputs
   assign ready_out  = ~full;
   assign resp_count = resp_q;
   assign err_count  = err_q;
   assign timeout    = timeout_q;
   assign fail       = (state_q == StFailed);

endmodule

// File: tb/tb_cache_resp_check.sv
// Self-checking bench for cache_resp_check: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_cache_resp_check;

   localparam int unsigned AW      = 16;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned TIMEOUT = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_fire = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          resp_valid = 1'b0;
   logic [31:0]   resp_data = '0;
   logic          ready_out;
   logic [15:0]   resp_count, err_count;
   logic          timeout, fail;
`ifdef CACHE_RESP_CHECK_CAPTURE_EN
   logic [AW-1:0] first_err_addr;
   logic [31:0]   first_err_data;
`endif

   cache_resp_check #(
      .AW      (AW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_fire       (req_fire),
      .req_addr       (req_addr),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .ready_out      (ready_out),
      .resp_count     (resp_count),
      .err_count      (err_count),
      .timeout        (timeout),
`ifdef CACHE_RESP_CHECK_CAPTURE_EN
      .first_err_addr (first_err_addr),
      .first_err_data (first_err_data),
`endif
      .fail           (fail)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [15:0] mq[$];
   int          m_resp, m_err, m_tmo;
   bit          m_timeout, m_fail;
   logic [15:0] m_cap_addr;
   logic [31:0] m_cap_data;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_exp(input logic [15:0] a);
      return {16'hFFFF ^ a, a};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_resp = 0; m_err = 0; m_tmo = 0;
      m_timeout = 0; m_fail = 0;
      m_cap_addr = '0; m_cap_data = '0;
   endtask

   task automatic model_err(input logic [15:0] a, input logic [31:0] d);
      if (!m_fail) begin
         m_cap_addr = a;
         m_cap_data = d;
      end
      m_fail = 1;
      if (m_err < 65535) m_err++;
   endtask

   // One clock of behaviour from the pre-edge model state and this cycle's inputs
   task automatic model_step(input bit f, input logic [15:0] a, input bit rv,
                             input logic [31:0] d);
      bit          was_empty, was_full;
      logic [15:0] h;
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      if (rv) begin
         if (m_resp < 65535) m_resp++;
         if (was_empty) model_err(16'h0, 32'h0);
         else begin
            h = mq.pop_front();
            if (d != ref_exp(h)) model_err(h, d);
         end
      end
      if (f) begin
         if (was_full) model_err(16'h0, 32'h0);
         else mq.push_back(a);
      end
      if (was_empty || rv) m_tmo = 0;
      else if (m_tmo < int'(TIMEOUT)) begin
         m_tmo++;
         if (m_tmo == int'(TIMEOUT)) begin
            m_timeout = 1;
            model_err(16'h0, 32'h0);
         end
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".ready"},   ready_out, (mq.size() < DEPTH));
      check_eq({tag, ".resp"},    resp_count, m_resp);
      check_eq({tag, ".err"},     err_count, m_err);
      check_eq({tag, ".timeout"}, timeout, m_timeout);
      check_eq({tag, ".fail"},    fail, m_fail);
`ifdef CACHE_RESP_CHECK_CAPTURE_EN
      check_eq({tag, ".cap_addr"}, first_err_addr, m_cap_addr);
      check_eq({tag, ".cap_data"}, first_err_data, m_cap_data);
`endif
   endtask

   // Drive one cycle of inputs, advance the model, sample after the edge
   task automatic step(input string tag, input bit f, input logic [15:0] a, input bit rv,
                       input logic [31:0] d);
      req_fire = f; req_addr = a; resp_valid = rv; resp_data = d;
      model_step(f, a, rv, d);
      @(posedge clk);
      #1;
      req_fire = 0; resp_valid = 0;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      model_reset();
      #1;
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset("rst0");

      // Four in-order requests, each answered three cycles later
      step("t1", 1, 16'h0000, 0, 32'h0);
      step("t1", 1, 16'h0004, 0, 32'h0);
      step("t1", 1, 16'h0008, 0, 32'h0);
      step("t1", 1, 16'h000C, 1, 32'hFFFF0000);
      step("t1", 0, 16'h0000, 1, 32'hFFFB0004);
      step("t1", 0, 16'h0000, 1, 32'hFFF70008);
      step("t1", 0, 16'h0000, 1, 32'hFFF3000C);
      check_eq("t1_resp4", resp_count, 32'd4);
      check_eq("t1_err0",  err_count, 32'd0);
      check_eq("t1_fail0", fail, 1'b0);

      // Data mismatch
      do_reset("rst2");
      step("t2", 1, 16'h0004, 0, 32'h0);
      step("t2", 0, 16'h0000, 1, 32'h00000000);
      check_eq("t2_err1",  err_count, 32'd1);
      check_eq("t2_fail1", fail, 1'b1);
`ifdef CACHE_RESP_CHECK_CAPTURE_EN
      check_eq("t2_cap_addr", first_err_addr, 32'h4);
      check_eq("t2_cap_data", first_err_data, 32'h0);
`endif

      // Fill to DEPTH, then overflow; draining proves the 9th address was dropped
      do_reset("rst3");
      for (int i = 0; i < int'(DEPTH); i++) step("t3fill", 1, 16'(i), 0, 32'h0);
      check_eq("t3_ready0", ready_out, 1'b0);
      check_eq("t3_err0",   err_count, 32'd0);
      step("t3ovf", 1, 16'h00AA, 0, 32'h0);
      check_eq("t3_err1",  err_count, 32'd1);
      check_eq("t3_fail1", fail, 1'b1);
      for (int i = 0; i < int'(DEPTH); i++) step("t3drain", 0, 16'h0, 1, ref_exp(16'(i)));
      check_eq("t3_err_after_drain", err_count, 32'd1);
      check_eq("t3_ready1", ready_out, 1'b1);

      // Unexpected response with a same-cycle push
      do_reset("rst4");
      step("t4", 1, 16'h0008, 1, 32'h12345678);
      check_eq("t4_err1", err_count, 32'd1);
      step("t4", 0, 16'h0000, 1, 32'hFFF70008);
      check_eq("t4_err_still1", err_count, 32'd1);
      check_eq("t4_resp2", resp_count, 32'd2);

      // Lost response timeout
      do_reset("rst5");
      step("t5push", 1, 16'h0010, 0, 32'h0);
      for (int i = 1; i < int'(TIMEOUT); i++) step("t5wait", 0, 16'h0, 0, 32'h0);
      check_eq("t5_tmo_early", timeout, 1'b0);
      step("t5wait", 0, 16'h0, 0, 32'h0);
      check_eq("t5_tmo_set", timeout, 1'b1);
      check_eq("t5_err1", err_count, 32'd1);
      step("t5resp", 0, 16'h0, 1, 32'hFFEF0010);
      check_eq("t5_tmo_sticky", timeout, 1'b1);
      check_eq("t5_resp1", resp_count, 32'd1);
      check_eq("t5_err_still1", err_count, 32'd1);

      // Asynchronous reset mid-burst
      do_reset("rst6");
      step("t6", 1, 16'h0100, 0, 32'h0);
      step("t6", 1, 16'h0101, 1, 32'h0);
      step("t6", 1, 16'h0102, 0, 32'h0);
      step("t6", 1, 16'h0103, 0, 32'h0);
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      check_eq("t6_async_resp", resp_count, 32'd0);
      check_eq("t6_async_err",  err_count, 32'd0);
      check_eq("t6_async_fail", fail, 1'b0);
      check_eq("t6_async_ready", ready_out, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      step("t6post", 1, 16'h0055, 0, 32'h0);
      step("t6post", 0, 16'h0000, 1, 32'hFFAA0055);
      check_eq("t6_post_err", err_count, 32'd0);
      check_eq("t6_post_resp", resp_count, 32'd1);

      // Random traffic
      for (int blk = 0; blk < 4; blk++) begin
         do_reset("rrst");
         for (int i = 0; i < 150; i++) begin
            bit          f, rv;
            logic [15:0] a;
            logic [31:0] d;
            f  = ($urandom_range(0, 99) < 40);
            a  = 16'($urandom);
            rv = ($urandom_range(0, 99) < 35);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8) d = ref_exp(mq[0]);
            else d = $urandom;
            step("rnd", f, a, rv, d);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
